// File: rtl/bram_port_master_if.sv
// Request/response stream and BRAM port bundle for bram_port_master.
// All buses use big-endian bit numbering ([0:n], bit 0 = MSB).
// The master modport is the bram_port_master view; slave is its environment.
interface bram_port_master_if;
    logic        Req_Valid;
    logic        Req_Ready;
    logic        Req_Write;
    logic [0:31] Req_Addr;
    logic [0:63] Req_Data;
    logic [0:1]  Req_BE;

    logic        Rsp_Valid;
    logic        Rsp_Ready;
    logic [0:63] Rsp_Data;
    logic        Rsp_Err;

    logic        BRAM_EN;
    logic [0:1]  BRAM_WEN;
    logic [0:31] BRAM_Addr;
    logic [0:63] BRAM_Dout;
    logic [0:63] BRAM_Din;

    modport master (
        input  Req_Valid, Req_Write, Req_Addr, Req_Data, Req_BE, Rsp_Ready, BRAM_Din,
        output Req_Ready, Rsp_Valid, Rsp_Data, Rsp_Err,
        output BRAM_EN, BRAM_WEN, BRAM_Addr, BRAM_Dout
    );

    modport slave (
        output Req_Valid, Req_Write, Req_Addr, Req_Data, Req_BE, Rsp_Ready, BRAM_Din,
        input  Req_Ready, Rsp_Valid, Rsp_Data, Rsp_Err,
        input  BRAM_EN, BRAM_WEN, BRAM_Addr, BRAM_Dout
    );
endinterface

// File: rtl/bram_port_master.sv
// Initiator for one 64-bit, 2-write-enable BRAM port. Turns a valid/ready request
// stream into registered BRAM port cycles and returns read data, in request order,
// through a credit-guarded response FIFO.
// Optional feature: define BRAM_PORT_MASTER_ADDR_CHECK_EN to range-check requests
// against C_BASEADDR/C_MEMSIZE; out-of-range reads answer 64'hDEADBEEF_DEADBEEF
// with Rsp_Err=1 and out-of-range writes are dropped.
module bram_port_master #(
    parameter logic [31:0] C_BASEADDR  = 32'h0000_0000,
    parameter int unsigned C_MEMSIZE   = 32'h0000_4000,
    parameter int unsigned C_RSP_DEPTH = 4
) (
    input logic                BRAM_Clk,
    input logic                BRAM_Rst,
    bram_port_master_if.master bus
);
    localparam int unsigned     CntW    = $clog2(C_RSP_DEPTH + 1);
    localparam int unsigned     PtrW    = $clog2(C_RSP_DEPTH);
    localparam logic [CntW-1:0] CredMax = CntW'(C_RSP_DEPTH);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(C_RSP_DEPTH - 1);
    localparam logic [0:63]     ErrData = 64'hDEAD_BEEF_DEAD_BEEF;

    // Elaboration-time parameter sanity checks.
    if (C_MEMSIZE < 8 || (C_MEMSIZE & (C_MEMSIZE - 1)) != 0) begin : g_bad_memsize
        $error("C_MEMSIZE must be a power of two of at least 8");
    end
    // The BRAM decodes low address bits itself, so the base must be size-aligned.
    if ((C_BASEADDR & 32'(C_MEMSIZE - 1)) != 32'd0) begin : g_bad_baseaddr
        $error("C_BASEADDR must be aligned to C_MEMSIZE");
    end
    if (C_RSP_DEPTH < 2 || C_RSP_DEPTH > 16) begin : g_bad_depth
        $error("C_RSP_DEPTH must be in 2..16");
    end

    logic            rst_q;
    logic [CntW-1:0] cred_q, cred_d;
    logic            s1_rd_q, s1_err_q, s2_rd_q, s2_err_q;
    logic            en_q, en_d;
    logic [0:1]      wen_q, wen_d;
    logic [0:31]     addr_q, addr_d;
    logic [0:63]     dout_q, dout_d;
    logic [0:63]     fifo_data_q [C_RSP_DEPTH];
    logic            fifo_err_q [C_RSP_DEPTH];
    logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic req_ready, accept, rd_accept, in_range;
    logic push, pop, fifo_valid;

    // Credits cover FIFO entries plus reads still in the BRAM pipeline, so a
    // granted read always has a FIFO slot waiting for it.
    assign req_ready  = !rst_q && (cred_q < CredMax);
    assign accept     = bus.Req_Valid && req_ready;
    assign rd_accept  = accept && !bus.Req_Write;
    assign fifo_valid = (cnt_q != '0);
    assign pop        = fifo_valid && bus.Rsp_Ready;
    assign push       = s2_rd_q;

`ifdef BRAM_PORT_MASTER_ADDR_CHECK_EN
    logic [31:0] req_offset;
    // Unsigned wrap makes addresses below the base land out of range too.
    assign req_offset = bus.Req_Addr - C_BASEADDR;
    assign in_range   = (req_offset < 32'(C_MEMSIZE));
`else
    assign in_range = 1'b1;
`endif

    // BRAM port next state: pulse EN/WEN for one cycle per accepted in-range request.
    always_comb begin
        en_d   = 1'b0;
        wen_d  = 2'b00;
        addr_d = addr_q;
        dout_d = dout_q;
        if (accept && in_range) begin
            en_d   = 1'b1;
            addr_d = bus.Req_Addr & ~32'h0000_0007;
            if (bus.Req_Write) begin
                wen_d  = bus.Req_BE;
                dout_d = bus.Req_Data;
            end
        end
    end

    // Credit counter: +1 per read accepted, -1 per response popped.
    always_comb begin
        cred_d = cred_q;
        if (rd_accept && !pop) begin
            cred_d = cred_q + CntW'(1);
        end else if (!rd_accept && pop) begin
            cred_d = cred_q - CntW'(1);
        end
    end

    // Response FIFO pointer and occupancy next state.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push) begin
            wptr_d = (wptr_q == PtrLast) ? '0 : wptr_q + PtrW'(1);
        end
        if (pop) begin
            rptr_d = (rptr_q == PtrLast) ? '0 : rptr_q + PtrW'(1);
        end
        if (push && !pop) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (!push && pop) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    // Registered reset copy gates Req_Ready for the whole reset cycle and one after.
    always_ff @(posedge BRAM_Clk) begin
        rst_q <= BRAM_Rst;
    end

    // Control state: port registers, read-tag pipeline, credits and FIFO pointers.
    always_ff @(posedge BRAM_Clk) begin
        if (BRAM_Rst) begin
            cred_q   <= '0;
            en_q     <= 1'b0;
            wen_q    <= 2'b00;
            addr_q   <= '0;
            dout_q   <= '0;
            s1_rd_q  <= 1'b0;
            s1_err_q <= 1'b0;
            s2_rd_q  <= 1'b0;
            s2_err_q <= 1'b0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
        end else begin
            cred_q   <= cred_d;
            en_q     <= en_d;
            wen_q    <= wen_d;
            addr_q   <= addr_d;
            dout_q   <= dout_d;
            s1_rd_q  <= rd_accept;
            s1_err_q <= rd_accept && !in_range;
            s2_rd_q  <= s1_rd_q;
            s2_err_q <= s1_err_q;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // FIFO storage: stage 2 captures BRAM_Din, or the error pattern for a rejected read.
    always_ff @(posedge BRAM_Clk) begin
        if (push) begin
            fifo_data_q[wptr_q] <= s2_err_q ? ErrData : bus.BRAM_Din;
            fifo_err_q[wptr_q]  <= s2_err_q;
        end
    end

    assign bus.Req_Ready = req_ready;
    assign bus.Rsp_Valid = fifo_valid;
    assign bus.Rsp_Data  = fifo_valid ? fifo_data_q[rptr_q] : '0;
    assign bus.Rsp_Err   = fifo_valid && fifo_err_q[rptr_q];
    assign bus.BRAM_EN   = en_q;
    assign bus.BRAM_WEN  = wen_q;
    assign bus.BRAM_Addr = addr_q;
    assign bus.BRAM_Dout = dout_q;
endmodule

// File: tb/tb_bram_port_master.sv
// Directed bench for bram_port_master with a 16 KB BRAM behavioural model.
// Memory word w is preloaded with {32'hA0000000 + w, 32'hB0000000 + w}.
module tb_bram_port_master;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_acc;
    int   n_rsp;

    bram_port_master_if bus ();

    bram_port_master #(
        .C_BASEADDR (32'h0000_0000),
        .C_MEMSIZE  (32'h0000_4000),
        .C_RSP_DEPTH(4)
    ) dut (
        .BRAM_Clk(clk),
        .BRAM_Rst(rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] exp_word(input int w);
        return {32'hA000_0000 + 32'(w), 32'hB000_0000 + 32'(w)};
    endfunction

    // BRAM: byte-write per 32-bit half, registered read-first output.
    logic [0:63] mem [2048];
    logic [10:0] widx;
    assign widx = bus.BRAM_Addr[18:28];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2048; i++) mem[i] <= exp_word(i);
        end else if (bus.BRAM_EN) begin
            if (bus.BRAM_WEN[0]) mem[widx][0:31] <= bus.BRAM_Dout[0:31];
            if (bus.BRAM_WEN[1]) mem[widx][32:63] <= bus.BRAM_Dout[32:63];
            bus.BRAM_Din <= mem[widx];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue n_req reads from base_word upward over n_cyc cycles, popping and checking
    // responses whenever Rsp_Ready is high.
    task automatic run_reads(input int base_word, input int n_req, input int n_cyc);
        for (int c = 0; c < n_cyc; c++) begin
            logic acc;
            logic pp;
            if (n_acc < n_req) begin
                bus.Req_Valid = 1'b1;
                bus.Req_Write = 1'b0;
                bus.Req_Addr  = 32'((base_word + n_acc) * 8);
            end else begin
                bus.Req_Valid = 1'b0;
            end
            acc = bus.Req_Valid && bus.Req_Ready;
            pp  = bus.Rsp_Valid && bus.Rsp_Ready;
            if (pp) begin
                check("ordered_rsp_data", bus.Rsp_Data, exp_word(base_word + n_rsp));
                n_rsp++;
            end
            tick();
            if (acc) n_acc++;
        end
        bus.Req_Valid = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.Req_Valid = 1'b1;
        bus.Req_Write = 1'b0;
        bus.Req_Addr  = 32'h0;
        bus.Req_Data  = 64'h0;
        bus.Req_BE    = 2'b00;
        bus.Rsp_Ready = 1'b1;

        // Reset held three cycles with a pending request.
        tick();
        check("rst_req_ready", 64'(bus.Req_Ready), 64'd0);
        check("rst_rsp_valid", 64'(bus.Rsp_Valid), 64'd0);
        check("rst_rsp_data", bus.Rsp_Data, 64'd0);
        check("rst_rsp_err", 64'(bus.Rsp_Err), 64'd0);
        check("rst_bram_en", 64'(bus.BRAM_EN), 64'd0);
        check("rst_bram_wen", 64'(bus.BRAM_WEN), 64'd0);
        check("rst_bram_addr", 64'(bus.BRAM_Addr), 64'd0);
        check("rst_bram_dout", bus.BRAM_Dout, 64'd0);
        tick();
        check("rst2_bram_en", 64'(bus.BRAM_EN), 64'd0);
        tick();
        check("rst3_req_ready", 64'(bus.Req_Ready), 64'd0);
        rst = 1'b0;
        tick();
        check("post_rst_req_ready", 64'(bus.Req_Ready), 64'd1);
        check("post_rst_bram_en", 64'(bus.BRAM_EN), 64'd0);
        bus.Req_Valid = 1'b0;

        // Write upper word only, then read it back.
        bus.Req_Valid = 1'b1;
        bus.Req_Write = 1'b1;
        bus.Req_Addr  = 32'h0000_0008;
        bus.Req_Data  = 64'h0123_4567_89AB_CDEF;
        bus.Req_BE    = 2'b10;
        tick();
        check("wr_bram_en", 64'(bus.BRAM_EN), 64'd1);
        check("wr_bram_wen", 64'(bus.BRAM_WEN), 64'd2);
        check("wr_bram_addr", 64'(bus.BRAM_Addr), 64'h8);
        check("wr_bram_dout", bus.BRAM_Dout, 64'h0123_4567_89AB_CDEF);
        bus.Req_Write = 1'b0;
        tick();
        bus.Req_Valid = 1'b0;
        check("rd_bram_en", 64'(bus.BRAM_EN), 64'd1);
        check("rd_bram_wen", 64'(bus.BRAM_WEN), 64'd0);
        check("rd_rsp_valid_k1", 64'(bus.Rsp_Valid), 64'd0);
        tick();
        check("rd_rsp_valid_k2m", 64'(bus.Rsp_Valid), 64'd0);
        check("idle_bram_en", 64'(bus.BRAM_EN), 64'd0);
        check("idle_bram_addr_hold", 64'(bus.BRAM_Addr), 64'h8);
        tick();
        check("rd_rsp_valid_k2", 64'(bus.Rsp_Valid), 64'd1);
        check("rd_rsp_data", bus.Rsp_Data, 64'h0123_4567_B000_0001);
        check("rd_rsp_err", 64'(bus.Rsp_Err), 64'd0);
        tick();
        check("rd_popped", 64'(bus.Rsp_Valid), 64'd0);

        // Eight back-to-back reads with Rsp_Ready held high.
        for (int c = 0; c < 10; c++) begin
            if (c < 8) begin
                bus.Req_Valid = 1'b1;
                bus.Req_Write = 1'b0;
                bus.Req_Addr  = 32'((32 + c) * 8);
                check("b2b_req_ready", 64'(bus.Req_Ready), 64'd1);
            end else begin
                bus.Req_Valid = 1'b0;
            end
            tick();
            if (c >= 2) begin
                check("b2b_rsp_valid", 64'(bus.Rsp_Valid), 64'd1);
                check("b2b_rsp_data", bus.Rsp_Data, exp_word(32 + c - 2));
            end
        end
        tick();
        check("b2b_drained", 64'(bus.Rsp_Valid), 64'd0);

        // Stall the consumer: exactly four reads fit, then drain in order.
        bus.Rsp_Ready = 1'b0;
        n_acc = 0;
        n_rsp = 0;
        run_reads(64, 6, 8);
        check("stall_accepted", 64'(n_acc), 64'd4);
        check("stall_req_ready", 64'(bus.Req_Ready), 64'd0);
        check("stall_rsp_valid", 64'(bus.Rsp_Valid), 64'd1);
        check("stall_rsp_hold", bus.Rsp_Data, exp_word(64));
        bus.Rsp_Ready = 1'b1;
        run_reads(64, 6, 12);
        check("drain_accepted", 64'(n_acc), 64'd6);
        check("drain_responses", 64'(n_rsp), 64'd6);
        check("drain_empty", 64'(bus.Rsp_Valid), 64'd0);

        // Reset one cycle after a read accept discards the in-flight read.
        bus.Req_Valid = 1'b1;
        bus.Req_Write = 1'b0;
        bus.Req_Addr  = 32'h0000_0028;
        check("flush_req_ready", 64'(bus.Req_Ready), 64'd1);
        tick();
        bus.Req_Valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("flush_ready_back", 64'(bus.Req_Ready), 64'd1);
        for (int c = 0; c < 5; c++) begin
            check("flush_no_rsp", 64'(bus.Rsp_Valid), 64'd0);
            tick();
        end
        bus.Rsp_Ready = 1'b0;
        n_acc = 0;
        n_rsp = 0;
        run_reads(100, 6, 8);
        check("flush_cred_zero", 64'(n_acc), 64'd4);
        bus.Rsp_Ready = 1'b1;
        run_reads(100, 6, 14);
        check("flush_drain", 64'(n_rsp), 64'd6);

`ifdef BRAM_PORT_MASTER_ADDR_CHECK_EN
        // Out-of-range write is swallowed without a port cycle.
        bus.Req_Valid = 1'b1;
        bus.Req_Write = 1'b1;
        bus.Req_Addr  = 32'h0000_4000;
        bus.Req_Data  = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.Req_BE    = 2'b11;
        tick();
        check("oor_wr_bram_en", 64'(bus.BRAM_EN), 64'd0);
        // Out-of-range read returns the error pattern at normal latency.
        bus.Req_Write = 1'b0;
        tick();
        bus.Req_Valid = 1'b0;
        check("oor_rd_bram_en", 64'(bus.BRAM_EN), 64'd0);
        tick();
        check("oor_rd_k1", 64'(bus.Rsp_Valid), 64'd0);
        tick();
        check("oor_rd_valid", 64'(bus.Rsp_Valid), 64'd1);
        check("oor_rd_data", bus.Rsp_Data, 64'hDEAD_BEEF_DEAD_BEEF);
        check("oor_rd_err", 64'(bus.Rsp_Err), 64'd1);
        tick();
        // Last in-range word.
        bus.Req_Valid = 1'b1;
        bus.Req_Addr  = 32'h0000_3FF8;
        tick();
        bus.Req_Valid = 1'b0;
        check("inr_bram_en", 64'(bus.BRAM_EN), 64'd1);
        check("inr_bram_addr", 64'(bus.BRAM_Addr), 64'h3FF8);
        tick();
        tick();
        check("inr_rd_valid", 64'(bus.Rsp_Valid), 64'd1);
        check("inr_rd_data", bus.Rsp_Data, 64'hA000_07FF_B000_07FF);
        check("inr_rd_err", 64'(bus.Rsp_Err), 64'd0);
        tick();
        // Word 0 must not have been hit by the dropped write.
        bus.Req_Valid = 1'b1;
        bus.Req_Addr  = 32'h0000_0000;
        tick();
        bus.Req_Valid = 1'b0;
        tick();
        tick();
        check("oor_wr_dropped", bus.Rsp_Data, 64'hA000_0000_B000_0000);
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
